avalon_mm_burst_slave_mem: RTL and testbench

Synthesizable Avalon-MM slave (responder) backed by an internal byte-lane memory. It is the RTL target driven by the Avalon MM master VIP in block-level benches, and it replaces the slave VIP once DUT-level integration starts. It supports write bursts, pipelined read bursts with readdatavalid, and configurable waitrequest insertion.

---
 rtl/avalon_mm_burst_slave_mem.sv | 240 ++++++++++++++++++++++++
 tb/tb_avalon_mm_burst_slave_mem.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_burst_slave_mem.sv
// Avalon-MM burst slave backed by a byte-lane memory with pipelined read bursts.
// Define AVS_PROT_CHECK_EN to build the sticky protocol checker driving prot_err.
module avalon_mm_burst_slave_mem #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int BURST_W      = 4,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_CYCLES  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic [BURST_W-1:0]    burstcount,
    input  logic                  beginbursttransfer,
    output logic [DATA_W-1:0]     readdata,
    output logic                  waitrequest,
    output logic                  readdatavalid,
    output logic                  prot_err
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] WCNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1);
    localparam logic [ADDR_W-1:0]  ONE_A = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WR_BURST,
        S_RD_BUSY
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_wcnt, w_wcnt_nxt;
    logic [ADDR_W-1:0]  r_cur_addr, w_cur_addr_nxt;
    logic [BURST_W-1:0] r_rem, w_rem_nxt;
    logic [BURST_W-1:0] r_ocnt, w_ocnt_nxt;

    logic               w_cmd;
    logic               w_is_wr;
    logic               w_accept;
    logic [BURST_W-1:0] w_len;
    logic               w_mem_we;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic               w_iss_v;
    logic [ADDR_W-1:0]  w_iss_addr;
    logic               w_fetch_v;
    logic [ADDR_W-1:0]  w_fetch_addr;

    logic [DATA_W-1:0]  r_mem [0:(1<<ADDR_W)-1];
    logic               r_pv  [0:READ_LATENCY-1];
    logic [ADDR_W-1:0]  r_pa  [0:READ_LATENCY-1];
    logic [DATA_W-1:0]  r_rdata;

    assign w_cmd    = chipselect & (read | write);
    assign w_is_wr  = chipselect & write;
    assign w_len    = (burstcount == '0) ? ONE_B : burstcount;
    assign w_accept = w_cmd &
        (((r_state == S_IDLE) && (WAIT_CYCLES == 0)) ||
         ((r_state == S_WAIT) && (r_wcnt == 4'd0)));

    assign readdatavalid = r_pv[READ_LATENCY-1];
    assign readdata      = readdatavalid ? r_rdata : '0;

    always_comb begin
        w_state_nxt    = r_state;
        w_wcnt_nxt     = r_wcnt;
        w_cur_addr_nxt = r_cur_addr;
        w_rem_nxt      = r_rem;
        w_ocnt_nxt     = r_ocnt;
        w_mem_we       = 1'b0;
        w_mem_addr     = r_cur_addr + ONE_A;
        w_iss_v        = 1'b0;
        w_iss_addr     = r_cur_addr + ONE_A;
        waitrequest    = 1'b0;
        if (w_accept) begin
            w_cur_addr_nxt = address;
            w_rem_nxt      = w_len - ONE_B;
            if (w_is_wr) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = address;
                w_state_nxt = (w_len == ONE_B) ? S_IDLE : S_WR_BURST;
            end else begin
                w_iss_v     = 1'b1;
                w_iss_addr  = address;
                w_ocnt_nxt  = w_len;
                w_state_nxt = S_RD_BUSY;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_cmd) begin
                        waitrequest = 1'b1;
                        w_wcnt_nxt  = WCNT_INIT;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    waitrequest = (r_wcnt != 4'd0);
                    if (!w_cmd) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_wcnt_nxt = r_wcnt - 4'd1;
                    end
                end
                S_WR_BURST: begin
                    if (w_is_wr) begin
                        w_mem_we       = 1'b1;
                        w_cur_addr_nxt = r_cur_addr + ONE_A;
                        w_rem_nxt      = r_rem - ONE_B;
                        if (r_rem == ONE_B) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_RD_BUSY: begin
                    waitrequest = 1'b1;
                    if (r_rem != '0) begin
                        w_iss_v        = 1'b1;
                        w_cur_addr_nxt = r_cur_addr + ONE_A;
                        w_rem_nxt      = r_rem - ONE_B;
                    end
                    // Leave once the final beat is on the bus.
                    if (readdatavalid) begin
                        w_ocnt_nxt = r_ocnt - ONE_B;
                        if (r_ocnt == ONE_B) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        if (reset) begin
            waitrequest = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wcnt     <= 4'd0;
            r_cur_addr <= '0;
            r_rem      <= '0;
            r_ocnt     <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pa[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_cur_addr <= w_cur_addr_nxt;
            r_rem      <= w_rem_nxt;
            r_ocnt     <= w_ocnt_nxt;
            r_pv[0]    <= w_iss_v;
            r_pa[0]    <= w_iss_addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
            end
        end
    end

    // Synchronous read taken one stage before the output so data lines up with valid.
    generate
        if (READ_LATENCY == 1) begin : g_fetch_direct
            assign w_fetch_v    = w_iss_v;
            assign w_fetch_addr = w_iss_addr;
        end else begin : g_fetch_pipe
            assign w_fetch_v    = r_pv[READ_LATENCY-2];
            assign w_fetch_addr = r_pa[READ_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byteenable[b]) begin
                    r_mem[w_mem_addr][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
        if (w_fetch_v) begin
            r_rdata <= r_mem[w_fetch_addr];
        end
    end

`ifdef AVS_PROT_CHECK_EN
    localparam int MAX_BURST = 1 << (BURST_W - 1);

    logic              r_prot_err;
    logic              w_viol;
    logic [ADDR_W-1:0] r_wait_addr;

    always_comb begin
        w_viol = chipselect & read & write;
        if (w_accept && (burstcount == '0)) begin
            w_viol = 1'b1;
        end
        if (w_accept && (int'(burstcount) > MAX_BURST)) begin
            w_viol = 1'b1;
        end
        if (w_accept && w_is_wr && !beginbursttransfer) begin
            w_viol = 1'b1;
        end
        if ((r_state == S_WR_BURST) && w_is_wr && beginbursttransfer) begin
            w_viol = 1'b1;
        end
        if ((r_state == S_WAIT) && w_cmd && (address != r_wait_addr)) begin
            w_viol = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prot_err  <= 1'b0;
            r_wait_addr <= '0;
        end else begin
            r_prot_err <= r_prot_err | w_viol;
            if ((r_state == S_IDLE) && w_cmd) begin
                r_wait_addr <= address;
            end
        end
    end

    assign prot_err = r_prot_err;
`else
    logic w_unused;
    assign w_unused = beginbursttransfer;
    assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_mm_burst_slave_mem.sv
// Scoreboard bench for avalon_mm_burst_slave_mem: WAIT_CYCLES=0 (inst 0) and 3 (inst 1).
module tb_avalon_mm_burst_slave_mem;

    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;
`ifdef AVS_PROT_CHECK_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    logic        clk;
    logic        rst   [2];
    logic [AW-1:0] addr[2];
    logic [3:0]  be    [2];
    logic        cs    [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] wd    [2];
    logic [3:0]  bc    [2];
    logic        bbt   [2];
    logic [31:0] rdata [2];
    logic        wreq  [2];
    logic        rdv   [2];
    logic        perr  [2];

    logic [31:0] mdl [2][DEPTH];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int n_chk = 0;
    int n_pass = 0;
    int rdv_cnt0 = 0;
    int rdv_cnt1 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    avalon_mm_burst_slave_mem #(
        .DATA_W(32), .ADDR_W(AW), .BURST_W(4),
        .READ_LATENCY(2), .WAIT_CYCLES(0)
    ) u_a (
        .clk(clk), .reset(rst[0]), .address(addr[0]),
        .byteenable(be[0]), .chipselect(cs[0]), .read(rd[0]),
        .write(wr[0]), .writedata(wd[0]), .burstcount(bc[0]),
        .beginbursttransfer(bbt[0]), .readdata(rdata[0]),
        .waitrequest(wreq[0]), .readdatavalid(rdv[0]),
        .prot_err(perr[0])
    );

    avalon_mm_burst_slave_mem #(
        .DATA_W(32), .ADDR_W(AW), .BURST_W(4),
        .READ_LATENCY(2), .WAIT_CYCLES(3)
    ) u_b (
        .clk(clk), .reset(rst[1]), .address(addr[1]),
        .byteenable(be[1]), .chipselect(cs[1]), .read(rd[1]),
        .write(wr[1]), .writedata(wd[1]), .burstcount(bc[1]),
        .beginbursttransfer(bbt[1]), .readdata(rdata[1]),
        .waitrequest(wreq[1]), .readdatavalid(rdv[1]),
        .prot_err(perr[1])
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rdv[0] === 1'b1) begin
            rdv_cnt0++;
            if (q0.size() == 0) chk("rdv_a_unexpected", 32'd1, 32'd0);
            else chk("rdata_a", rdata[0], q0.pop_front());
        end
        if (rdv[1] === 1'b1) begin
            rdv_cnt1++;
            if (q1.size() == 0) chk("rdv_b_unexpected", 32'd1, 32'd0);
            else chk("rdata_b", rdata[1], q1.pop_front());
        end
    end

    task automatic idle(int i);
        cs[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; bbt[i] = 1'b0;
        bc[i] = 4'd1; be[i] = 4'h0; wd[i] = '0; addr[i] = '0;
    endtask

    task automatic mdl_wr(int i, int a, logic [31:0] d, logic [3:0] b);
        for (int k = 0; k < 4; k++)
            if (b[k]) mdl[i][a % DEPTH][k*8 +: 8] = d[k*8 +: 8];
    endtask

    task automatic wait_acc(int i, string tag, output int stalls);
        stalls = 0;
        #1;
        while (wreq[i] === 1'b1 && stalls < 40) begin
            @(negedge clk); #1; stalls++;
        end
        if (wreq[i] !== 1'b0) chk({tag, "_acc_timeout"}, 32'(wreq[i]), 32'd0);
    endtask

    task automatic wr1(int i, int a, logic [31:0] d, logic [3:0] b);
        int s;
        @(negedge clk);
        cs[i] = 1'b1; wr[i] = 1'b1; rd[i] = 1'b0; addr[i] = a[AW-1:0];
        wd[i] = d; be[i] = b; bc[i] = 4'd1; bbt[i] = 1'b1;
        wait_acc(i, "wr1", s);
        chk("wr1_stall", s, (i == 0) ? 0 : 3);
        mdl_wr(i, a, d, b);
        @(negedge clk); idle(i);
    endtask

    task automatic wrb(int i, int a, int n, int gap_at, int gap_len, logic [31:0] base);
        int s;
        @(negedge clk);
        cs[i] = 1'b1; wr[i] = 1'b1; rd[i] = 1'b0; addr[i] = a[AW-1:0];
        wd[i] = base; be[i] = 4'hF; bc[i] = n[3:0]; bbt[i] = 1'b1;
        wait_acc(i, "wrb", s);
        chk("wrb_stall", s, (i == 0) ? 0 : 3);
        mdl_wr(i, a, base, 4'hF);
        for (int k = 1; k < n; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk); wr[i] = 1'b0; bbt[i] = 1'b0;
                    #1 chk("wrb_gap_wreq", 32'(wreq[i]), 32'd0);
                end
            end
            @(negedge clk);
            wr[i] = 1'b1; bbt[i] = 1'b0; wd[i] = base + 32'(k);
            #1 chk("wrb_beat_wreq", 32'(wreq[i]), 32'd0);
            mdl_wr(i, a + k, base + 32'(k), 4'hF);
        end
        @(negedge clk); idle(i);
    endtask

    task automatic rdn(int i, int a, int n);
        int s;
        @(negedge clk);
        cs[i] = 1'b1; rd[i] = 1'b1; wr[i] = 1'b0; addr[i] = a[AW-1:0];
        bc[i] = n[3:0]; bbt[i] = 1'b1; be[i] = 4'hF;
        wait_acc(i, "rdn", s);
        chk("rdn_stall", s, (i == 0) ? 0 : 3);
        for (int k = 0; k < n; k++) begin
            if (i == 0) q0.push_back(mdl[0][(a + k) % DEPTH]);
            else q1.push_back(mdl[1][(a + k) % DEPTH]);
        end
        @(negedge clk); idle(i);
    endtask

    task automatic drain(int i);
        int c;
        int sz;
        c = 0;
        sz = (i == 0) ? q0.size() : q1.size();
        while (sz != 0 && c < 100) begin
            @(negedge clk); #1; c++;
            sz = (i == 0) ? q0.size() : q1.size();
        end
        chk((i == 0) ? "drain_a" : "drain_b", sz, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int c;
        int base;
        idle(0); idle(1);
        rst[0] = 1'b1; rst[1] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wreq_a", 32'(wreq[0]), 32'd1);
        chk("rst_rdv_a", 32'(rdv[0]), 32'd0);
        chk("rst_rdata_a", rdata[0], 32'd0);
        chk("rst_perr_a", 32'(perr[0]), 32'd0);
        chk("rst_wreq_b", 32'(wreq[1]), 32'd1);
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1 chk("idle_wreq_a", 32'(wreq[0]), 32'd0);

        // single write then read, exact read timing
        wr1(0, 'h010, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        cs[0] = 1'b1; rd[0] = 1'b1; addr[0] = 10'h010; bc[0] = 4'd1; bbt[0] = 1'b1;
        #1 chk("t1_wreq_T", 32'(wreq[0]), 32'd0);
        q0.push_back(mdl[0][16]);
        @(negedge clk); idle(0);
        #1;
        chk("t1_wreq_T1", 32'(wreq[0]), 32'd1);
        chk("t1_rdv_T1", 32'(rdv[0]), 32'd0);
        chk("t1_rdata_zero", rdata[0], 32'd0);
        @(negedge clk); #1;
        chk("t1_rdv_T2", 32'(rdv[0]), 32'd1);
        chk("t1_rdata_T2", rdata[0], 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("t1_rdv_T3", 32'(rdv[0]), 32'd0);
        chk("t1_wreq_T3", 32'(wreq[0]), 32'd0);
        drain(0);

        // byteenable merge
        wr1(0, 5, 32'h11223344, 4'hF);
        wr1(0, 5, 32'hAABBCCDD, 4'h5);
        rdn(0, 5, 1);
        drain(0);

        // wrapping write burst with idle beats, then contiguous read burst
        wrb(0, 'h3FE, 4, 2, 2, 32'hC0DE0000);
        rdn(0, 'h3FE, 4);
        c = 0;
        while (rdv[0] !== 1'b1 && c < 20) begin
            @(negedge clk); #1; c++;
        end
        chk("t3_first_rdv", 32'(rdv[0]), 32'd1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); #1 chk("t3_contig", 32'(rdv[0]), 32'd1);
        end
        @(negedge clk); #1 chk("t3_end", 32'(rdv[0]), 32'd0);
        drain(0);

        // waitrequest stall on the WAIT_CYCLES=3 instance
        wr1(1, 0, 32'h5A5A0001, 4'hF);
        @(negedge clk);
        cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = '0; bc[1] = 4'd1; bbt[1] = 1'b1;
        wait_acc(1, "t4", s);
        chk("t4_stall", s, 3);
        q1.push_back(mdl[1][0]);
        @(negedge clk); idle(1);
        drain(1);

        // command dropped after one stall cycle
        base = rdv_cnt1;
        @(negedge clk);
        cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = '0; bc[1] = 4'd1; bbt[1] = 1'b1;
        #1 chk("t4_drop_wreq0", 32'(wreq[1]), 32'd1);
        @(negedge clk); idle(1);
        @(negedge clk); #1 chk("t4_drop_idle", 32'(wreq[1]), 32'd0);
        repeat (10) @(negedge clk);
        #1 chk("t4_drop_no_rdv", rdv_cnt1 - base, 0);
        rdn(1, 0, 1);
        drain(1);

        // reset in the middle of an 8-beat read
        wrb(0, 'h100, 8, 0, 0, 32'h80000000);
        rdn(0, 'h100, 8);
        base = rdv_cnt0;
        c = 0;
        while (rdv_cnt0 - base < 2 && c < 20) begin
            @(negedge clk); #1; c++;
        end
        chk("t5_beats_before_rst", rdv_cnt0 - base, 2);
        #1 rst[0] = 1'b1;
        #1;
        chk("t5_rdv_rst", 32'(rdv[0]), 32'd0);
        chk("t5_rdata_rst", rdata[0], 32'd0);
        chk("t5_wreq_rst", 32'(wreq[0]), 32'd1);
        q0.delete();
        @(negedge clk); #1;
        chk("t5_wreq_rst_hold", 32'(wreq[0]), 32'd1);
        chk("t5_rdv_rst_hold", 32'(rdv[0]), 32'd0);
        @(negedge clk); rst[0] = 1'b0;
        #1 chk("t5_wreq_release", 32'(wreq[0]), 32'd0);
        rdn(0, 'h100, 8);
        drain(0);

        // simultaneous read and write: write wins, checker flags it
        @(negedge clk); #1 chk("t6_perr_pre", 32'(perr[0]), 32'd0);
        @(negedge clk);
        cs[0] = 1'b1; rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 10'h020;
        wd[0] = 32'h600DF00D; be[0] = 4'hF; bc[0] = 4'd1; bbt[0] = 1'b1;
        wait_acc(0, "t6", s);
        mdl_wr(0, 'h020, 32'h600DF00D, 4'hF);
        @(negedge clk); idle(0);
        #1 chk("t6_perr_set", 32'(perr[0]), 32'(EXP_PERR));
        repeat (3) @(negedge clk);
        #1 chk("t6_perr_sticky", 32'(perr[0]), 32'(EXP_PERR));
        rdn(0, 'h020, 1);
        drain(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
